// File: rtl/vad_energy_detector.sv
// ---------------------------------------------------------------------------
// vad_energy_detector
//   Energy-based voice activity detector on the ADC capture path. It sits
//   directly after the I2S controller's adc_data_out / adc_data_valid.
//
//   Each valid sample is rectified to a saturating magnitude and summed over
//   a fixed window of 2^WIN_LOG2 valid samples. At each window end the mean
//   level is published, and a SILENT/ACTIVE/HANG state machine is stepped.
//   The machine uses two thresholds for hysteresis, and it waits HANGOVER
//   quiet windows before dropping voice_active.
//
//   Samples are forwarded with one cycle of latency. When the optional gate
//   is built in, samples captured while voice_active is low are zeroed.
//
//   Build option:
//     VAD_GATE_EN  - if defined, sample_out is forced to 0 whenever
//                    voice_active is low on the capture edge. If undefined,
//                    voice_active is only advisory.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     sample_in         signed ADC sample
//     sample_valid      one-cycle strobe qualifying sample_in
//     thresh_on         unsigned level at or above which SILENT -> ACTIVE
//     thresh_off        unsigned level below which ACTIVE starts hangover
//     sample_out        forwarded (optionally gated) sample, 1 cycle late
//     sample_out_valid  sample_valid delayed by 1 cycle
//     level_out         mean magnitude of the last completed window
//     level_valid       one-cycle pulse when level_out updates
//     voice_active      high in ACTIVE and HANG
// ---------------------------------------------------------------------------
module vad_energy_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 8,   // 1..12
  parameter int HANGOVER   = 4    // 0..255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic        [DATA_WIDTH-1:0] thresh_on,
  input  logic        [DATA_WIDTH-1:0] thresh_off,
  output logic        [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic        [DATA_WIDTH-1:0] level_out,
  output logic                         level_valid,
  output logic                         voice_active
);

  // The sum of 2^WIN_LOG2 magnitudes, each below 2^(DATA_WIDTH-1), always
  // fits in this width, so no overflow guard is needed.
  localparam int ACC_W = DATA_WIDTH + WIN_LOG2;

  localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [7:0]            HANG_INIT = 8'(HANGOVER);

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    ACTIVE = 2'd1,
    HANG   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            hang_cnt, hang_nxt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_sum;
  logic [WIN_LOG2-1:0]   cnt;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] level_new;
  logic                  win_end;

  // -------------------------------------------------------------------------
  // Rectifier. The most-negative code has no positive counterpart, so it is
  // clamped to full scale instead of wrapping back to itself.
  // -------------------------------------------------------------------------
  always_comb begin
    mag = sample_in;
    if (sample_in == MOST_NEG)
      mag = MAG_MAX;
    else if (sample_in[DATA_WIDTH-1])
      mag = DATA_WIDTH'(-sample_in);
  end

  // The window-ending sample is folded into the level here, so the
  // accumulator can restart from 0 on the same edge.
  assign acc_sum   = acc + ACC_W'(mag);
  assign level_new = DATA_WIDTH'(acc_sum >> WIN_LOG2);
  assign win_end   = sample_valid && (cnt == {WIN_LOG2{1'b1}});

  // -------------------------------------------------------------------------
  // Activity FSM - next state. It steps only at window end, so the
  // thresholds are looked at only then.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    hang_nxt  = hang_cnt;
    if (win_end) begin
      unique case (state)
        SILENT: begin
          if (level_new >= thresh_on)
            state_nxt = ACTIVE;
        end
        ACTIVE: begin
          if (level_new < thresh_off) begin
            if (HANGOVER == 0) begin
              state_nxt = SILENT;
            end else begin
              state_nxt = HANG;
              hang_nxt  = HANG_INIT;
            end
          end
        end
        HANG: begin
          // One quiet window has already been spent entering HANG. As a
          // result, voice_active drops after HANGOVER+1 quiet windows.
          if (level_new >= thresh_off)
            state_nxt = ACTIVE;
          else if (hang_cnt <= 8'd1)
            state_nxt = SILENT;
          else
            hang_nxt = hang_cnt - 8'd1;
        end
        default: state_nxt = SILENT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Activity FSM - state register. voice_active is registered from the next
  // state, so it moves on the same edge that raises level_valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SILENT;
      hang_cnt     <= 8'd0;
      voice_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      hang_cnt     <= hang_nxt;
      voice_active <= (state_nxt != SILENT);
    end
  end

  // -------------------------------------------------------------------------
  // Window accumulator and level output. Idle cycles hold all state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      level_out   <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= win_end;
      if (sample_valid) begin
        // The counter wraps to 0 by itself after the all-ones value.
        cnt <= cnt + WIN_LOG2'(1);
        if (win_end) begin
          acc       <= '0;
          level_out <= level_new;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Passthrough. The gate uses voice_active as it stands on the capture
  // edge. For the window-ending sample, that is the value before the update.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= sample_valid;
      if (sample_valid) begin
`ifdef VAD_GATE_EN
        sample_out <= voice_active ? sample_in : '0;
`else
        sample_out <= sample_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vad_energy_detector.sv
// ---------------------------------------------------------------------------
// tb_vad_energy_detector
//   Directed bench for vad_energy_detector with 4-sample windows,
//   HANGOVER=2, thresh_on=500 and thresh_off=200. Expected levels are the
//   hand-computed mean magnitudes of each window. The expected voice_active
//   track (cur_va) is stepped by hand after each window.
// ---------------------------------------------------------------------------
module tb_vad_energy_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] thresh_on;
  logic [15:0] thresh_off;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic [15:0] level_out;
  logic        level_valid;
  logic        voice_active;

  int   nvec = 0;
  int   nerr = 0;
  logic cur_va = 1'b0;

  vad_energy_detector #(
    .DATA_WIDTH(16),
    .WIN_LOG2  (2),
    .HANGOVER  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .thresh_on       (thresh_on),
    .thresh_off      (thresh_off),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .level_out       (level_out),
    .level_valid     (level_valid),
    .voice_active    (voice_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. It drives one valid sample across the next posedge
  // and returns at the following negedge, where the outputs are stable.
  task automatic push(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  function automatic logic [15:0] gated(input logic [15:0] v, input logic va);
`ifdef VAD_GATE_EN
    return va ? v : 16'h0000;
`else
    return (va === 1'bx) ? 16'hxxxx : v;
`endif
  endfunction

  // One full window followed by one idle cycle.
  task automatic win4(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input logic [15:0] s3,
                      input logic [15:0] lvl, input logic va);
    logic [15:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      push(s[i]);
      chk({tag, ".sov"}, 16'(sample_out_valid), 16'd1);
      chk({tag, ".so"},  sample_out, gated(s[i], cur_va));
      if (i < 3) begin
        chk({tag, ".lv_mid"}, 16'(level_valid), 16'd0);
        chk({tag, ".va_mid"}, 16'(voice_active), 16'(cur_va));
      end
    end
    chk({tag, ".lv"},    16'(level_valid), 16'd1);
    chk({tag, ".level"}, level_out, lvl);
    chk({tag, ".va"},    16'(voice_active), 16'(va));
    cur_va = va;
    @(negedge clk);
    chk({tag, ".lv_pulse"}, 16'(level_valid), 16'd0);
    chk({tag, ".sov_idle"}, 16'(sample_out_valid), 16'd0);
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = 16'h0000;
    sample_valid = 1'b0;
    thresh_on    = 16'd500;
    thresh_off   = 16'd200;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.so",    sample_out, 16'h0);
    chk("rst.sov",   16'(sample_out_valid), 16'd0);
    chk("rst.level", level_out, 16'h0);
    chk("rst.lv",    16'(level_valid), 16'd0);
    chk("rst.va",    16'(voice_active), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel.lv",    16'(level_valid), 16'd0);

    // Partial window discarded by reset
    push(16'd1000);
    push(16'd1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.sov", 16'(sample_out_valid), 16'd0);
    chk("midrst.so",  sample_out, 16'h0);
    win4("zero", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

    // Average across an idle gap; gating uses the pre-update voice_active
    push(16'd1000);
    push(16'd1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap.sov",  16'(sample_out_valid), 16'd0);
      chk("gap.hold", sample_out, gated(16'd1000, 1'b0));
      chk("gap.lv",   16'(level_valid), 16'd0);
    end
    push(16'd1000);
    chk("w1.lv3", 16'(level_valid), 16'd0);
    push(16'd1000);
    chk("w1.lv",    16'(level_valid), 16'd1);
    chk("w1.level", level_out, 16'd1000);
    chk("w1.va",    16'(voice_active), 16'd1);
    chk("w1.so",    sample_out, gated(16'd1000, 1'b0));
    cur_va = 1'b1;
    @(negedge clk);
    chk("w1.pulse", 16'(level_valid), 16'd0);

    // ACTIVE windows, including a signed mix and hysteresis
    win4("w600", 16'hFDA8, 16'h0258, 16'hFDA8, 16'h0258, 16'd600, 1'b1);
    win4("w300", 16'd300, 16'hFED4, 16'd300, 16'hFED4, 16'd300, 1'b1);

    // Saturation and truncation; truncated 0 is the 1st quiet window
    win4("sat",   16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd32767, 1'b1);
    win4("trunc", 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    win4("q2",    16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    win4("w250",  16'd250, 16'd250, 16'd250, 16'd250, 16'd250, 1'b1);

    // Hangover: drops on the 3rd consecutive quiet window
    win4("hq1", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    win4("hq2", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    win4("hq3", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

    // Passthrough while SILENT (gated if built in), then while ACTIVE
    win4("pt_sil", 16'h1234, 16'd0, 16'd0, 16'd0, 16'd1165, 1'b1);
    win4("pt_act", 16'h1234, 16'd0, 16'd0, 16'd0, 16'd1165, 1'b1);

    // Threshold boundaries
    win4("off_eq", 16'd200, 16'd200, 16'd200, 16'd200, 16'd200, 1'b1);
    win4("off_lo", 16'd199, 16'd199, 16'd199, 16'd199, 16'd199, 1'b1);
    win4("hq_b",   16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    win4("hq_c",   16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    win4("on_lo",  16'd499, 16'd499, 16'd499, 16'd499, 16'd499, 1'b0);
    win4("on_eq",  16'd500, 16'd500, 16'd500, 16'd500, 16'd500, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
